// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR transmit bit path: sequencer states,
// the default frame sync pattern and the payload word size.
package sdr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SYNC,
      ST_LENGTH,
      ST_PAYLOAD,
      ST_GAP
   } tx_seq_state_t;

   localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACFFC1D;
   localparam int          WORD_BITS         = 32;

endpackage

// File: rtl/tx_frame_sequencer_if.sv
// Single-bit valid/ready stream; the producer uses master, the consumer slave.
interface tx_frame_sequencer_if;

   logic valid;
   logic data;
   logic ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/field_serializer.sv
// MSB-first shift register for a header field of programmable bit count;
// shifts one position per accepted beat and flags the final bit.
module field_serializer #(
   parameter int W  = 32,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [W-1:0]  load_field,
   input  logic [CW-1:0] load_count,
   input  logic          shift,
   output logic          bit_out,
   output logic          last
);

   logic [W-1:0]  shreg;
   logic [CW-1:0] remaining;

   // A load wins over a shift so the next field can be queued on the final
   // beat of the current one without a bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg     <= '0;
         remaining <= '0;
      end else if (load) begin
         shreg     <= load_field;
         remaining <= load_count;
      end else if (shift && remaining != '0) begin
         shreg     <= {shreg[W-2:0], 1'b0};
         remaining <= remaining - CW'(1);
      end
   end

   assign bit_out = shreg[W-1];
   assign last    = (remaining == CW'(1));

endmodule

// File: rtl/tx_frame_sequencer.sv
// Transmit frame sequencer: wraps packager payload bits with a generated
// preamble, sync word and length header, then closes with a zero-bit gap.
module tx_frame_sequencer
   import sdr_pkg::*;
#(
   parameter int          PREAMBLE_BITS = 32,
   parameter logic [31:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
   parameter int          LEN_W         = 16,
   parameter int          GAP_BITS      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_W-1:0]     frame_len,
   tx_frame_sequencer_if.slave  s_bus,
   tx_frame_sequencer_if.master m_bus,
   output logic                 busy,
   output logic                 done,
   output logic                 underrun
);

   localparam int WORD_LOG = $clog2(WORD_BITS);
   localparam int CNT_W    = LEN_W + WORD_LOG;
   localparam int SER_W    = (LEN_W > WORD_BITS) ? LEN_W : WORD_BITS;
   localparam int SER_CW   = $clog2(SER_W + 1);

   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BITS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_BITS - 1);

   tx_seq_state_t     state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [LEN_W-1:0]  len_q;
   logic [CNT_W-1:0]  pay_last;

   logic              m_valid;
   logic              m_data;
   logic              s_ready;
   logic              hs;

   logic              ser_bit;
   logic              ser_last;
   logic              ser_load;
   logic              ser_shift;
   logic [SER_W-1:0]  ser_field;
   logic [SER_CW-1:0] ser_count;

   // Counter is wide enough for the largest payload, so this never wraps.
   assign pay_last = {len_q, {WORD_LOG{1'b0}}} - CNT_W'(1);

   // Queue the sync word on the last preamble beat and the length field on
   // the last sync beat, so each header field is ready as its state begins.
   always_comb begin
      ser_load  = 1'b0;
      ser_field = '0;
      ser_count = '0;
      if (state == ST_PREAMBLE && hs && bit_cnt == PRE_LAST) begin
         ser_load  = 1'b1;
         ser_field = SER_W'(SYNC_WORD) << (SER_W - WORD_BITS);
         ser_count = SER_CW'(WORD_BITS);
      end else if (state == ST_SYNC && hs && ser_last) begin
         ser_load  = 1'b1;
         ser_field = SER_W'(len_q) << (SER_W - LEN_W);
         ser_count = SER_CW'(LEN_W);
      end
   end

   assign ser_shift = hs && (state == ST_SYNC || state == ST_LENGTH);

   field_serializer #(
      .W  (SER_W),
      .CW (SER_CW)
   ) u_field_serializer (
      .clk        (clk),
      .rst        (rst),
      .load       (ser_load),
      .load_field (ser_field),
      .load_count (ser_count),
      .shift      (ser_shift),
      .bit_out    (ser_bit),
      .last       (ser_last)
   );

   always_comb begin
      m_valid = 1'b0;
      m_data  = 1'b0;
      s_ready = 1'b0;
      case (state)
         ST_PREAMBLE: begin
            m_valid = 1'b1;
            m_data  = ~bit_cnt[0];
         end
         ST_SYNC, ST_LENGTH: begin
            m_valid = 1'b1;
            m_data  = ser_bit;
         end
         ST_PAYLOAD: begin
            m_valid = s_bus.valid;
            m_data  = s_bus.valid & s_bus.data;
            s_ready = m_bus.ready;
         end
         ST_GAP: begin
            m_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign hs          = m_valid & m_bus.ready;
   assign m_bus.valid = m_valid;
   assign m_bus.data  = m_data;
   assign s_bus.ready = s_ready;
   assign busy        = (state != ST_IDLE);

   // Sequencer FSM; the bit counter restarts on every section change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         len_q    <= '0;
         underrun <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  len_q    <= frame_len;
                  underrun <= 1'b0;
                  bit_cnt  <= '0;
                  state    <= ST_PREAMBLE;
               end
            end
            ST_PREAMBLE: begin
               if (hs) begin
                  if (bit_cnt == PRE_LAST) begin
                     bit_cnt <= '0;
                     state   <= ST_SYNC;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            ST_SYNC: begin
               if (hs) begin
                  if (ser_last) begin
                     bit_cnt <= '0;
                     state   <= ST_LENGTH;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            ST_LENGTH: begin
               if (hs) begin
                  if (ser_last) begin
                     bit_cnt <= '0;
                     state   <= (len_q == '0) ? ST_GAP : ST_PAYLOAD;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            ST_PAYLOAD: begin
               if (m_bus.ready && !s_bus.valid) begin
                  underrun <= 1'b1;
               end
               if (hs) begin
                  if (bit_cnt == pay_last) begin
                     bit_cnt <= '0;
                     state   <= ST_GAP;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            ST_GAP: begin
               if (hs) begin
                  if (bit_cnt == GAP_LAST) begin
                     bit_cnt <= '0;
                     done    <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               bit_cnt <= '0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
